// File: rtl/instruction_fetch.sv
// Fetch front end for the instruction RAM: one-in-flight SETUP/READ fetch loop
// feeding a 2-entry {pc, word} prefetch queue toward the decoder.
//
// state | meaning
// IDLE  | not fetching, waiting for start or redirect
// SETUP | address on ADDBUS, RD low, waits for a free queue slot
// READ  | RD high for one cycle, word captured at end of cycle
// HALT  | end word fetched, queue drains, waits for redirect
module instruction_fetch #(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 16,
  parameter int                MEM_DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [DATA_W-1:0] HALT_WORD  = 16'hF100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ADDBUS,
  output logic              RD,
  input  logic [DATA_W-1:0] DATAIN,
  output logic [DATA_W-1:0] ins_out,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic              busy
);

  localparam int PC_W = $clog2(MEM_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt;
  logic              rd_q;
  logic [1:0]        count;
  logic [1:0]        count_after_pop;
  logic              pop, push;
  logic [DATA_W-1:0] hd_word, tl_word;
  logic [PC_W-1:0]   hd_pc, tl_pc;

  generate
    if (PC_W < ADDR_W) begin : g_unused_hi
      logic unused_redirect_hi;
      assign unused_redirect_hi = ^redirect_addr[ADDR_W-1:PC_W];
    end
  endgenerate

  assign pop             = (count != 2'd0) && ins_ready;
  assign push            = (state == S_READ) && !redirect;
  assign count_after_pop = count - {1'b0, pop};

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (redirect) begin
      state_nxt = S_SETUP;
      pc_nxt    = redirect_addr[PC_W-1:0];
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_SETUP;
            pc_nxt    = START_ADDR[PC_W-1:0];
          end
        end
        S_SETUP: begin
          if (count_after_pop != 2'd2) state_nxt = S_READ;
        end
        S_READ: begin
          // pc is PC_W bits wide, so the increment wraps modulo MEM_DEPTH
          pc_nxt    = pc + 1'b1;
          state_nxt = (DATAIN == HALT_WORD) ? S_HALT : S_SETUP;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      rd_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      rd_q  <= (state_nxt == S_READ);
    end
  end

  // READ is only entered with a free slot, so a push never finds the queue full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= 2'd0;
      hd_word <= '0;
      hd_pc   <= '0;
      tl_word <= '0;
      tl_pc   <= '0;
    end else if (redirect) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            hd_word <= DATAIN;
            hd_pc   <= pc;
          end else begin
            tl_word <= DATAIN;
            tl_pc   <= pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          hd_word <= tl_word;
          hd_pc   <= tl_pc;
          count   <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            hd_word <= tl_word;
            hd_pc   <= tl_pc;
            tl_word <= DATAIN;
            tl_pc   <= pc;
          end else begin
            hd_word <= DATAIN;
            hd_pc   <= pc;
          end
        end
        default: count <= count;
      endcase
    end
  end

  assign ADDBUS    = ADDR_W'(pc);
  assign RD        = rd_q;
  assign ins_out   = hd_word;
  assign ins_pc    = ADDR_W'(hd_pc);
  assign ins_valid = (count != 2'd0);
  assign halted    = (state == S_HALT);
  assign busy      = (state == S_SETUP) || (state == S_READ);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: cycle table for streaming, directed corner
// sequences, then random ready/redirect against a PC-stream reference.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] addbus;
  logic        rd;
  logic [15:0] datain;
  logic [15:0] ins_out;
  logic [15:0] ins_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        halted;
  logic        busy;

  logic [15:0] ram [0:1023];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign datain = rd ? ram[addbus[9:0]] : 16'hDEAD;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .start(start),
    .ADDBUS(addbus), .RD(rd), .DATAIN(datain),
    .ins_out(ins_out), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .halted(halted), .busy(busy)
  );

  typedef struct {
    logic        vld;
    logic        rdv;
    logic [15:0] addr;
    logic [15:0] pc;
    logic [15:0] word;
  } vec_t;

  vec_t stream_tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; start = 1'b0; redirect = 1'b0; redirect_addr = '0; ins_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int k;
    for (k = 0; k < 20 && !ins_valid; k++) @(negedge clk);
    if (!ins_valid) chk({name, "_timeout"}, 32'(ins_valid), 32'd1);
  endtask

  task automatic wait_rd();
    int k;
    for (k = 0; k < 20 && !rd; k++) @(negedge clk);
    if (!rd) chk("rd_timeout", 32'(rd), 32'd1);
  endtask

  initial begin
    int          exp_pc;
    int          accepts;
    logic        done;
    logic        prev_rd;
    logic        r, y;
    logic [15:0] a;

    for (int i = 0; i < 1024; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w == 16'hF100) w = 16'h0001;
      ram[i] = w;
    end
    ram[0]  = 16'h0000; ram[1] = 16'h3004; ram[2] = 16'h2096; ram[3] = 16'h20C6;
    ram[26] = 16'h209A; ram[56] = 16'h0002; ram[57] = 16'hF100;
    ram[300] = 16'hF100; ram[700] = 16'hF100;

    stream_tbl[0] = '{1'b0, 1'b0, 16'd0, 16'd0, 16'h0000};
    stream_tbl[1] = '{1'b0, 1'b1, 16'd0, 16'd0, 16'h0000};
    stream_tbl[2] = '{1'b1, 1'b0, 16'd1, 16'd0, 16'h0000};
    stream_tbl[3] = '{1'b0, 1'b1, 16'd1, 16'd0, 16'h0000};
    stream_tbl[4] = '{1'b1, 1'b0, 16'd2, 16'd1, 16'h3004};
    stream_tbl[5] = '{1'b0, 1'b1, 16'd2, 16'd0, 16'h0000};
    stream_tbl[6] = '{1'b1, 1'b0, 16'd3, 16'd2, 16'h2096};
    stream_tbl[7] = '{1'b0, 1'b1, 16'd3, 16'd0, 16'h0000};
    stream_tbl[8] = '{1'b1, 1'b0, 16'd4, 16'd3, 16'h20C6};

    // reset values, then reset in the middle of a READ
    reset_dut();
    chk("rst_rd", 32'(rd), 0);
    chk("rst_addbus", 32'(addbus), 0);
    chk("rst_valid", 32'(ins_valid), 0);
    chk("rst_out", 32'(ins_out), 0);
    chk("rst_pc", 32'(ins_pc), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_busy", 32'(busy), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_rd", 32'(rd), 1);
    #1 rst = 1'b1;
    #1;
    chk("midread_rd", 32'(rd), 0);
    chk("midread_valid", 32'(ins_valid), 0);
    chk("midread_addbus", 32'(addbus), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_rd", 32'(rd), 0);
    chk("post_rst_valid", 32'(ins_valid), 0);

    // streaming table, cycles 1..9 after start
    ins_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("stream%0d_valid", i + 1), 32'(ins_valid), 32'(stream_tbl[i].vld));
      chk($sformatf("stream%0d_rd", i + 1), 32'(rd), 32'(stream_tbl[i].rdv));
      chk($sformatf("stream%0d_addbus", i + 1), 32'(addbus), 32'(stream_tbl[i].addr));
      if (stream_tbl[i].vld) begin
        chk($sformatf("stream%0d_pc", i + 1), 32'(ins_pc), 32'(stream_tbl[i].pc));
        chk($sformatf("stream%0d_word", i + 1), 32'(ins_out), 32'(stream_tbl[i].word));
      end
      @(negedge clk);
    end

    // backpressure
    reset_dut();
    ins_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("bp_valid", 32'(ins_valid), 1);
    chk("bp_pc", 32'(ins_pc), 0);
    chk("bp_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rd_low", 32'(rd), 0);
      chk("bp_addbus", 32'(addbus), 2);
      @(negedge clk);
    end
    ins_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_pc1", 32'(ins_pc), 1);
    chk("bp_drain_word1", 32'(ins_out), 32'(ram[1]));
    chk("bp_resume_rd", 32'(rd), 1);
    chk("bp_resume_addr", 32'(addbus), 2);
    @(negedge clk);
    chk("bp_pc2", 32'(ins_pc), 2);
    chk("bp_word2", 32'(ins_out), 32'(ram[2]));
    chk("bp_pc2_valid", 32'(ins_valid), 1);

    // redirect while a READ is in flight
    wait_rd();
    redirect = 1'b1;
    redirect_addr = 16'h001A;
    @(negedge clk);
    redirect = 1'b0;
    chk("redir_flush_valid", 32'(ins_valid), 0);
    chk("redir_rd", 32'(rd), 0);
    chk("redir_addbus", 32'(addbus), 32'h1A);
    @(negedge clk);
    chk("redir_read_valid", 32'(ins_valid), 0);
    chk("redir_read_rd", 32'(rd), 1);
    @(negedge clk);
    chk("redir_n3_valid", 32'(ins_valid), 1);
    chk("redir_pc", 32'(ins_pc), 32'h1A);
    chk("redir_word", 32'(ins_out), 32'h209A);

    // halt on end word
    redirect = 1'b1;
    redirect_addr = 16'd56;
    @(negedge clk);
    redirect = 1'b0;
    wait_valid("halt56");
    chk("halt_pc56", 32'(ins_pc), 56);
    chk("halt_word56", 32'(ins_out), 32'h0002);
    @(negedge clk);
    wait_valid("halt57");
    chk("halt_pc57", 32'(ins_pc), 57);
    chk("halt_word57", 32'(ins_out), 32'hF100);
    chk("halt_flag", 32'(halted), 1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("halt_rd_low", 32'(rd), 0);
      chk("halt_drained", 32'(ins_valid), 0);
      chk("halt_held", 32'(halted), 1);
      @(negedge clk);
    end
    redirect = 1'b1;
    redirect_addr = 16'd0;
    @(negedge clk);
    redirect = 1'b0;
    chk("unhalt_flag", 32'(halted), 0);
    chk("unhalt_busy", 32'(busy), 1);
    wait_valid("unhalt");
    chk("unhalt_pc", 32'(ins_pc), 0);

    // wrap at the top of memory
    redirect = 1'b1;
    redirect_addr = 16'd1023;
    @(negedge clk);
    redirect = 1'b0;
    wait_valid("wrap1023");
    chk("wrap_pc1023", 32'(ins_pc), 1023);
    chk("wrap_word1023", 32'(ins_out), 32'(ram[1023]));
    @(negedge clk);
    wait_valid("wrap0");
    chk("wrap_pc0", 32'(ins_pc), 0);
    chk("wrap_word0", 32'(ins_out), 32'(ram[0]));

    // start and redirect together in IDLE
    reset_dut();
    ins_ready = 1'b1;
    start = 1'b1;
    redirect = 1'b1;
    redirect_addr = 16'd5;
    @(negedge clk);
    start = 1'b0;
    redirect = 1'b0;
    chk("coll_addbus", 32'(addbus), 5);
    wait_valid("coll");
    chk("coll_pc", 32'(ins_pc), 5);
    chk("coll_word", 32'(ins_out), 32'(ram[5]));

    // random ready/redirect against the expected PC stream
    exp_pc  = 0;
    accepts = 0;
    done    = 1'b0;
    prev_rd = rd;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r = (cyc == 0) || ($urandom_range(0, 39) == 0);
      y = ($urandom_range(0, 3) != 0);
      a = 16'($urandom);
      ins_ready = y;
      redirect = r;
      redirect_addr = a;
      chk("rnd_addbus_hi", 32'(addbus[15:10]), 0);
      chk("rnd_rd_gap", 32'(prev_rd & rd), 0);
      if (r) begin
        exp_pc = int'(a) % 1024;
        done = 1'b0;
      end else if (ins_valid && y) begin
        chk("rnd_after_halt", 32'(done), 0);
        chk("rnd_pc", 32'(ins_pc), 32'(exp_pc));
        chk("rnd_word", 32'(ins_out), 32'(ram[exp_pc]));
        if (ram[exp_pc] == 16'hF100) done = 1'b1;
        exp_pc = (exp_pc + 1) % 1024;
        accepts++;
      end
      prev_rd = rd;
      @(negedge clk);
    end
    redirect = 1'b0;
    chk("rnd_progress", 32'(accepts > 300), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
